// File: rtl/stream_beta_window_if.sv
// Trellis description consumed by stream_beta_window: for every state and
// input bit, the successor state and the index of the emitted output symbol.
interface trellis_if #(
    parameter int STATES         = 4,
    parameter int OUTPUT_SYMBOLS = 4
);
    localparam int SW = (STATES > 1) ? $clog2(STATES) : 1;
    localparam int OW = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1;

    logic [STATES-1:0][1:0][SW-1:0] next_state;
    logic [STATES-1:0][1:0][OW-1:0] output_symbol;

    modport provider (output next_state, output output_symbol);
    modport consumer (input next_state, input output_symbol);
endinterface

// File: rtl/stream_beta_window.sv
// Backward (beta) metric engine for a MAP decoder window. A block of branch
// metric vectors is buffered, then betas are emitted from beta_N down to
// beta_1, each step being a saturating max-log recursion normalised so the
// best state sits at zero.
module stream_beta_window #(
    parameter int    BITS           = 16,
    parameter int    STATES         = 4,
    parameter int    DEPTH          = 64,
    parameter string INIT_MODE      = "TERMINATED",
    parameter int    OUTPUT_SYMBOLS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    trellis_if.consumer                   trellis,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          block_start,
    input  logic                          block_end,
    input  logic signed [BITS-1:0]        branch_metric [OUTPUT_SYMBOLS],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(DEPTH+1)-1:0]    out_index,
    output logic signed [BITS-1:0]        BetaMetric [STATES],
    output logic                          overflow
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit INIT_OPEN = (INIT_MODE == "OPEN");

    localparam logic [IW-1:0]          ONE_IDX   = IW'(1);
    localparam logic [IW-1:0]          DEPTH_IDX = IW'(DEPTH);
    localparam logic signed [BITS-1:0] MIN_V     = {1'b1, {(BITS-1){1'b0}}};
    localparam logic signed [BITS-1:0] MAX_V     = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS:0]   MIN_W     = {2'b11, {(BITS-1){1'b0}}};
    localparam logic signed [BITS:0]   MAX_W     = {2'b00, {(BITS-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Clamp a one-bit-wider intermediate back into the metric range.
    function automatic logic signed [BITS-1:0] sat_wide(input logic signed [BITS:0] v);
        if (v > MAX_W) begin
            return MAX_V;
        end else if (v < MIN_W) begin
            return MIN_V;
        end else begin
            return v[BITS-1:0];
        end
    endfunction

    function automatic logic signed [BITS-1:0] sat_add(input logic signed [BITS-1:0] a,
                                                       input logic signed [BITS-1:0] b);
        return sat_wide({a[BITS-1], a} + {b[BITS-1], b});
    endfunction

    function automatic logic signed [BITS-1:0] sat_sub(input logic signed [BITS-1:0] a,
                                                       input logic signed [BITS-1:0] b);
        return sat_wide({a[BITS-1], a} - {b[BITS-1], b});
    endfunction

    state_t                  state_q, state_d;
    logic [IW-1:0]           count_q, count_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    overflow_q, overflow_d;
    logic signed [BITS-1:0]  beta_q [STATES];
    logic signed [BITS-1:0]  beta_d [STATES];

    logic [OUTPUT_SYMBOLS*BITS-1:0] mem_q [DEPTH];

    logic                           xfer_s;
    logic                           wr_en_s;
    logic [AW-1:0]                  wr_addr_s;
    logic [AW-1:0]                  rd_addr_s;
    logic [IW-1:0]                  fill_count_s;
    logic                           go_run_s;
    logic                           ovf_set_s;
    logic [OUTPUT_SYMBOLS*BITS-1:0] wr_word_s;
    logic [OUTPUT_SYMBOLS*BITS-1:0] rd_word_s;
    logic signed [BITS-1:0]         gamma_s     [OUTPUT_SYMBOLS];
    logic signed [BITS-1:0]         cand0_s     [STATES];
    logic signed [BITS-1:0]         cand1_s     [STATES];
    logic signed [BITS-1:0]         t_s         [STATES];
    logic signed [BITS-1:0]         tmax_s;
    logic signed [BITS-1:0]         beta_next_s [STATES];
    logic signed [BITS-1:0]         beta_init_s [STATES];

    assign xfer_s    = in_valid & in_ready_q;
    assign rd_addr_s = AW'(idx_q - ONE_IDX);
    assign rd_word_s = mem_q[rd_addr_s];

    // Pack the incoming branch-metric vector into one buffer word.
    always_comb begin
        wr_word_s = '0;
        for (int o = 0; o < OUTPUT_SYMBOLS; o++) begin
            wr_word_s[o*BITS +: BITS] = branch_metric[o];
        end
    end

    // Input-side decode: buffer write address, fill count after the write and block completion.
    always_comb begin
        wr_en_s      = 1'b0;
        wr_addr_s    = {AW{1'b0}};
        fill_count_s = count_q;
        go_run_s     = 1'b0;
        ovf_set_s    = 1'b0;
        if (xfer_s && (state_q != ST_RUN)) begin
            if (block_start) begin
                wr_en_s      = 1'b1;
                wr_addr_s    = {AW{1'b0}};
                fill_count_s = ONE_IDX;
            end else if (state_q == ST_FILL) begin
                wr_en_s      = 1'b1;
                wr_addr_s    = AW'(count_q);
                fill_count_s = count_q + ONE_IDX;
            end else begin
                // Symbol outside any block: accepted and dropped.
                wr_en_s = 1'b0;
            end
            if (wr_en_s && block_end) begin
                go_run_s = 1'b1;
            end else if (wr_en_s && (fill_count_s == DEPTH_IDX)) begin
                go_run_s  = 1'b1;
                ovf_set_s = 1'b1;
            end else begin
                go_run_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Starting beta vector for a block.
    always_comb begin
        for (int s = 0; s < STATES; s++) begin
            beta_init_s[s] = (INIT_OPEN || (s == 0)) ? {BITS{1'b0}} : MIN_V;
        end
    end

    // One backward step: add-compare-select over both input bits, then normalise to max 0.
    always_comb begin
        for (int o = 0; o < OUTPUT_SYMBOLS; o++) begin
            gamma_s[o] = $signed(rd_word_s[o*BITS +: BITS]);
        end
        tmax_s = MIN_V;
        for (int s = 0; s < STATES; s++) begin
            cand0_s[s] = sat_add(beta_q[trellis.next_state[s][0]],
                                 gamma_s[trellis.output_symbol[s][0]]);
            cand1_s[s] = sat_add(beta_q[trellis.next_state[s][1]],
                                 gamma_s[trellis.output_symbol[s][1]]);
            t_s[s]     = (cand0_s[s] > cand1_s[s]) ? cand0_s[s] : cand1_s[s];
            if (t_s[s] > tmax_s) begin
                tmax_s = t_s[s];
            end else begin
                tmax_s = tmax_s;
            end
        end
        for (int s = 0; s < STATES; s++) begin
            beta_next_s[s] = sat_sub(t_s[s], tmax_s);
        end
    end

    // Control FSM: next state plus next values of every output register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        beta_d      = beta_q;
        overflow_d  = ovf_set_s | (overflow_q & ~(xfer_s & block_start));
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (go_run_s) begin
                    state_d     = ST_RUN;
                    count_d     = fill_count_s;
                    idx_d       = fill_count_s;
                    out_valid_d = 1'b1;
                    out_last_d  = (fill_count_s == ONE_IDX);
                    beta_d      = beta_init_s;
                end else if (wr_en_s) begin
                    state_d = ST_FILL;
                    count_d = fill_count_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (idx_q == ONE_IDX) begin
                        state_d     = ST_IDLE;
                        count_d     = {IW{1'b0}};
                        idx_d       = {IW{1'b0}};
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        for (int s = 0; s < STATES; s++) begin
                            beta_d[s] = {BITS{1'b0}};
                        end
                    end else begin
                        idx_d      = idx_q - ONE_IDX;
                        out_last_d = (idx_q == IW'(2));
                        beta_d     = beta_next_s;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                count_d     = {IW{1'b0}};
                idx_d       = {IW{1'b0}};
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                for (int s = 0; s < STATES; s++) begin
                    beta_d[s] = {BITS{1'b0}};
                end
            end
        endcase
        in_ready_d = (state_d != ST_RUN);
    end

    // State and output registers; everything visible returns to zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= {IW{1'b0}};
            idx_q       <= {IW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            for (int s = 0; s < STATES; s++) begin
                beta_q[s] <= {BITS{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            beta_q      <= beta_d;
        end
    end

    // Branch-metric buffer; contents survive reset and are overwritten block by block.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_word_s;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_index  = idx_q;
    assign overflow   = overflow_q;
    assign BetaMetric = beta_q;

endmodule

// File: tb/tb_stream_beta_window.sv
// Bench for stream_beta_window: a TERMINATED and an OPEN instance share all
// stimulus; a queue of expected outputs is filled when a block is closed and
// drained by a negedge monitor.
module tb_stream_beta_window;
    localparam int MINV = -32768;

    typedef int vec_t [4];
    typedef struct packed {
        logic [3:0]       idx;
        logic             last;
        logic [3:0][15:0] bt;
        logic [3:0][15:0] bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, block_start = 1'b0, block_end = 1'b0, out_ready = 1'b1;
    logic signed [15:0] bm [4];

    logic in_ready_t, out_valid_t, out_last_t, overflow_t;
    logic in_ready_o, out_valid_o, out_last_o, overflow_o;
    logic [3:0] out_index_t, out_index_o;
    logic signed [15:0] beta_t [4];
    logic signed [15:0] beta_o [4];

    trellis_if #(.STATES(4), .OUTPUT_SYMBOLS(4)) trl ();

    stream_beta_window #(.BITS(16), .STATES(4), .DEPTH(8), .INIT_MODE("TERMINATED"),
                         .OUTPUT_SYMBOLS(4)) dut_t (
        .clk(clk), .rst(rst), .trellis(trl), .in_valid(in_valid), .in_ready(in_ready_t),
        .block_start(block_start), .block_end(block_end), .branch_metric(bm),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_last(out_last_t),
        .out_index(out_index_t), .BetaMetric(beta_t), .overflow(overflow_t));

    stream_beta_window #(.BITS(16), .STATES(4), .DEPTH(8), .INIT_MODE("OPEN"),
                         .OUTPUT_SYMBOLS(4)) dut_o (
        .clk(clk), .rst(rst), .trellis(trl), .in_valid(in_valid), .in_ready(in_ready_o),
        .block_start(block_start), .block_end(block_end), .branch_metric(bm),
        .out_valid(out_valid_o), .out_ready(out_ready), .out_last(out_last_o),
        .out_index(out_index_o), .BetaMetric(beta_o), .overflow(overflow_o));

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   ns_tab [4][2];
    int   os_tab [4][2];
    int   blk_g  [8][4];
    exp_t sb  [$];
    exp_t cap [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference backward step using gammas of buffer slot k.
    task automatic model_step(input vec_t b, input int k, output vec_t r);
        int t [4];
        int m;
        m = -(1 << 30);
        for (int s = 0; s < 4; s++) begin
            int best;
            best = -(1 << 30);
            for (int u = 0; u < 2; u++) begin
                int v;
                v = sat16(b[ns_tab[s][u]] + blk_g[k][os_tab[s][u]]);
                if (v > best) best = v;
            end
            t[s] = best;
            if (best > m) m = best;
        end
        for (int s = 0; s < 4; s++) r[s] = sat16(t[s] - m);
    endtask

    task automatic push_block(input int n);
        vec_t bt, bo, nt, no;
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            bt[s] = (s == 0) ? 0 : MINV;
            bo[s] = 0;
        end
        for (int k = n; k >= 1; k--) begin
            e.idx  = 4'(k);
            e.last = (k == 1);
            for (int s = 0; s < 4; s++) begin
                e.bt[s] = 16'(bt[s]);
                e.bo[s] = 16'(bo[s]);
            end
            sb.push_back(e);
            if (k > 1) begin
                model_step(bt, k - 1, nt);
                bt = nt;
                model_step(bo, k - 1, no);
                bo = no;
            end
        end
    endtask

    task automatic send_vals(input int g0, input int g1, input int g2, input int g3,
                             input bit st, input bit en);
        int c;
        c = 0;
        @(negedge clk);
        in_valid = 1'b1; block_start = st; block_end = en;
        bm[0] = 16'(g0); bm[1] = 16'(g1); bm[2] = 16'(g2); bm[3] = 16'(g3);
        while (!in_ready_t && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_val("in_ready_wait", in_ready_t, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; block_start = 1'b0; block_end = 1'b0;
    endtask

    task automatic send_sym(input int k, input bit st, input bit en);
        send_vals(blk_g[k][0], blk_g[k][1], blk_g[k][2], blk_g[k][3], st, en);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_val("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic int vmax(input logic [63:0] p);
        int m;
        m = -(1 << 30);
        for (int s = 0; s < 4; s++) begin
            logic [15:0] w;
            w = p[s*16 +: 16];
            if (int'($signed(w)) > m) m = int'($signed(w));
        end
        return m;
    endfunction

    // Output monitor: validity, values, hold stability and idle zeros.
    exp_t        mon_e;
    logic        hold_pend = 1'b0;
    logic [68:0] hold_val;
    always @(negedge clk) begin
        if (!rst) begin
            check_val("valid_t", out_valid_t, sb.size() != 0);
            check_val("valid_o", out_valid_o, sb.size() != 0);
            if (hold_pend) begin
                check_val("hold", {out_index_t, out_last_t, beta_t[3], beta_t[2], beta_t[1], beta_t[0]},
                          hold_val);
            end
            hold_pend = 1'b0;
            if (out_valid_t && sb.size() != 0) begin
                mon_e = sb[0];
                check_val("index_t", out_index_t, mon_e.idx);
                check_val("last_t", out_last_t, mon_e.last);
                check_val("beta_t", {beta_t[3], beta_t[2], beta_t[1], beta_t[0]}, mon_e.bt);
                check_val("index_o", out_index_o, mon_e.idx);
                check_val("last_o", out_last_o, mon_e.last);
                check_val("beta_o", {beta_o[3], beta_o[2], beta_o[1], beta_o[0]}, mon_e.bo);
                check_val("max0_t", 64'(vmax({beta_t[3], beta_t[2], beta_t[1], beta_t[0]})), 64'd0);
                check_val("max0_o", 64'(vmax({beta_o[3], beta_o[2], beta_o[1], beta_o[0]})), 64'd0);
                if (out_ready) begin
                    cap.push_back({out_index_t, out_last_t, beta_t[3], beta_t[2], beta_t[1], beta_t[0],
                                   beta_o[3], beta_o[2], beta_o[1], beta_o[0]});
                    void'(sb.pop_front());
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = {out_index_t, out_last_t, beta_t[3], beta_t[2], beta_t[1], beta_t[0]};
                end
            end else if (!out_valid_t) begin
                check_val("idle_t", {out_last_t, out_index_t, beta_t[3], beta_t[2], beta_t[1], beta_t[0]}, 69'd0);
                check_val("idle_o", {out_last_o, out_index_o, beta_o[3], beta_o[2], beta_o[1], beta_o[0]}, 69'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int o = 0; o < 4; o++) bm[o] = 16'sd0;
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns_tab[s][u] = ((s << 1) | u) & 3;
                os_tab[s][u] = ((u ^ (s & 1) ^ (s >> 1)) << 1) | (u ^ (s >> 1));
                trl.next_state[s][u]    = 2'(ns_tab[s][u]);
                trl.output_symbol[s][u] = 2'(os_tab[s][u]);
            end
        end

        // Reset state
        #1 rst = 1'b1;
        #2;
        check_val("rst_ctl_t", {in_ready_t, out_valid_t, out_last_t, out_index_t, overflow_t}, 64'd0);
        check_val("rst_ctl_o", {in_ready_o, out_valid_o, out_last_o, out_index_o, overflow_o}, 64'd0);
        check_val("rst_beta_t", {beta_t[3], beta_t[2], beta_t[1], beta_t[0]}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_val("rdy_before_clk", in_ready_t, 1'b0);
        @(posedge clk);
        #1 check_val("rdy_after_rst", in_ready_t, 1'b1);

        // Terminated, zero gammas, N = 4
        cap.delete();
        for (int k = 0; k < 8; k++) for (int o = 0; o < 4; o++) blk_g[k][o] = 0;
        for (int k = 0; k < 4; k++) send_sym(k, k == 0, k == 3);
        push_block(4);
        wait_drain();
        check_val("t1_count", 64'(cap.size()), 64'd4);
        if (cap.size() == 4) begin
            check_val("t1_beta4", cap[0].bt, 64'h8000_8000_8000_0000);
            check_val("t1_beta3", cap[1].bt, 64'h8000_0000_8000_0000);
            check_val("t1_beta2", cap[2].bt, 64'd0);
            check_val("t1_beta1", cap[3].bt, 64'd0);
            check_val("t1_lasts", {cap[0].last, cap[1].last, cap[2].last, cap[3].last}, 4'b0001);
            check_val("t1_idx", {cap[0].idx, cap[1].idx, cap[2].idx, cap[3].idx}, 16'h4321);
        end

        // Single-symbol block
        cap.delete();
        blk_g[0][0] = 1234; blk_g[0][1] = -77; blk_g[0][2] = 5; blk_g[0][3] = 900;
        send_sym(0, 1'b1, 1'b1);
        push_block(1);
        wait_drain();
        check_val("t2_count", 64'(cap.size()), 64'd1);
        if (cap.size() == 1) begin
            check_val("t2_open", cap[0].bo, 64'd0);
            check_val("t2_idx_last", {cap[0].idx, cap[0].last}, 5'b0001_1);
        end

        // Random gammas, out_ready toggling 1,0,0,1
        for (int k = 0; k < 5; k++)
            for (int o = 0; o < 4; o++) blk_g[k][o] = int'($urandom_range(4000)) - 2000;
        for (int k = 0; k < 5; k++) send_sym(k, k == 0, k == 4);
        push_block(5);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // Restart on the third symbol of a fill
        for (int k = 0; k < 3; k++)
            for (int o = 0; o < 4; o++) blk_g[k][o] = int'($urandom_range(6000)) - 3000;
        send_vals(111, -222, 333, -444, 1'b1, 1'b0);
        send_vals(5, 6, 7, 8, 1'b0, 1'b0);
        send_sym(0, 1'b1, 1'b0);
        send_sym(1, 1'b0, 1'b0);
        send_sym(2, 1'b0, 1'b1);
        push_block(3);
        wait_drain();

        // Overflow: DEPTH transfers without block_end
        cap.delete();
        for (int k = 0; k < 8; k++)
            for (int o = 0; o < 4; o++) blk_g[k][o] = int'($urandom_range(1000)) - 500;
        for (int k = 0; k < 8; k++) begin
            send_sym(k, k == 0, 1'b0);
            if (k == 6) check_val("ovf_early", overflow_t, 1'b0);
        end
        push_block(8);
        check_val("ovf_set_t", overflow_t, 1'b1);
        check_val("ovf_set_o", overflow_o, 1'b1);
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 check_val("ninth_blocked", in_ready_t, 1'b0);
        end
        in_valid = 1'b0;
        wait_drain();
        check_val("ovf_outputs", 64'(cap.size()), 64'd8);
        check_val("ovf_sticky", overflow_t, 1'b1);

        // Large gammas, then reset in the middle of the run
        for (int k = 0; k < 4; k++) begin
            blk_g[k][0] = (k % 2 == 0) ? 30000 : -30000;
            blk_g[k][1] = -30000;
            blk_g[k][2] = 30000;
            blk_g[k][3] = (k % 2 == 0) ? -30000 : 30000;
        end
        for (int k = 0; k < 4; k++) begin
            send_sym(k, k == 0, k == 3);
            if (k == 0) check_val("ovf_clear", overflow_t, 1'b0);
        end
        push_block(4);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        hold_pend = 1'b0;
        check_val("mid_rst_ctl_t", {in_ready_t, out_valid_t, out_last_t, out_index_t, overflow_t}, 64'd0);
        check_val("mid_rst_ctl_o", {in_ready_o, out_valid_o, out_last_o, out_index_o, overflow_o}, 64'd0);
        check_val("mid_rst_beta_t", {beta_t[3], beta_t[2], beta_t[1], beta_t[0]}, 64'd0);
        check_val("mid_rst_beta_o", {beta_o[3], beta_o[2], beta_o[1], beta_o[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check_val("rdy_after_mid_rst", in_ready_t, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stream_beta_window.md
STREAM_BETA_WINDOW -- requirements
Module: stream_beta_window

Interface
- REQ-001: Parameter BITS, default 16: metric width, signed two's complement.
- REQ-002: Parameter STATES, default 4: trellis states; power of 2, at least 2.
- REQ-003: Parameter DEPTH, default 64: maximum block length in symbols; the buffer holds DEPTH branch-metric vectors.
- REQ-004: Parameter INIT_MODE, default "TERMINATED".
  - "TERMINATED": beta init is state 0 = 0, all others = MIN.
  - "OPEN": all states = 0.
- REQ-005: clk, input, 1: single clock; all state updates on the rising edge.
- REQ-006: rst, input, 1: reset, asynchronous and active-high.
- REQ-007: trellis, interface, n/a: trellis_if.
  - Supplies OUTPUT_SYMBOLS, next_state[s][u] and output_symbol[s][u] for u in {0,1}.
- REQ-008: in_valid, input, 1: branch-metric vector present.
- REQ-009: in_ready, output, 1: block accepts input; transfer occurs when in_valid and in_ready are both 1.
- REQ-010: block_start, input, 1: qualified by transfer; the symbol is index 0 of a new block.
- REQ-011: block_end, input, 1: qualified by transfer; the symbol is the last of the block.
- REQ-012: branch_metric[OUTPUT_SYMBOLS], input, BITS each: gamma_k, one entry per output symbol.
- REQ-013: out_valid, output, 1: BetaMetric is valid.
- REQ-014: out_ready, input, 1: downstream accepts output; handshake when out_valid and out_ready are both 1.
- REQ-015: out_last, output, 1: the current output is beta_1, the final output of the block.
- REQ-016: out_index, output, clog2(DEPTH+1): index k of the beta on BetaMetric.
- REQ-017: BetaMetric[STATES], output, BITS each: beta_k.
- REQ-018: overflow, output, 1: sticky flag; DEPTH was reached without block_end.

Function
- REQ-019: The FSM has three states: IDLE, FILL, RUN.
  - in_ready = 1 in IDLE and FILL; in_ready = 0 in RUN.
- REQ-020: IDLE transitions on a transfer with block_start.
  - The symbol is written to buf[0] and count = 1.
  - Next state is FILL, or RUN if block_end is also 1 (N = 1).
  - A transfer without block_start in IDLE is accepted and discarded.
- REQ-021: FILL behaviour on each transfer:
  - Normal transfer: write buf[count], count++.
  - Transfer with block_start: discard the partial block; write buf[0], count = 1.
  - Transfer with block_end: the block length is N = count after the write; next state is RUN.
- REQ-022: FILL overflow: a transfer that makes count = DEPTH without block_end sets overflow, sets N = DEPTH and enters RUN.
- REQ-023: RUN emits N outputs in order beta_N, beta_(N-1), ..., beta_1.
  - out_index = k; out_last = 1 only when k = 1.
- REQ-024: Latency: out_valid = 1 in the cycle after the transfer that ends FILL; the first output is the INIT_MODE vector with out_index = N.
- REQ-025: On each output handshake with k > 1, the beta register loads beta_(k-1) = F(beta_k, buf[k-1]).
- REQ-026: The output holds while out_valid = 1 and out_ready = 0; BetaMetric and out_index stay stable.
- REQ-027: A handshake with out_last = 1 returns the FSM to IDLE.
  - in_ready = 1 in the next cycle; there is no bubble beyond that one cycle.
- REQ-028: F definition: for each s, t[s] = max over u of sat(beta_k[next_state[s][u]] + gamma[output_symbol[s][u]]).
- REQ-029: Normalization: beta_(k-1)[s] = sat(t[s] - max_s t[s]), so every output has max = 0 and all values <= 0.
- REQ-030: sat() is saturating at [MIN, MAX] of BITS-bit signed, where MIN = -2^(BITS-1). MIN acts as minus infinity.
- REQ-031: When out_valid = 0, BetaMetric = 0, out_index = 0 and out_last = 0.
- REQ-032: overflow is cleared only by rst or by a transfer carrying block_start.

Reset
- REQ-033: While rst = 1, or at any time asynchronously:
  - FSM = IDLE, count = 0, the beta register is 0.
  - out_valid = 0, out_last = 0, out_index = 0, BetaMetric = 0, overflow = 0, in_ready = 0.
  - in_ready = 1 from the first clock after rst deasserts.
- REQ-034: rst asserted mid-RUN or mid-FILL abandons the block; no further outputs are produced for it.
- REQ-035: Buffer contents are not reset.

Verification
- REQ-036: Use the 4-state memory-2 trellis, BITS=16, DEPTH=8, TERMINATED, all gamma = 0, N = 4, out_ready = 1.
  - Required outputs: beta_4 = {0,-32768,-32768,-32768}; beta_3 has 0 on predecessors of state 0 and -32768 elsewhere; beta_2 = beta_1 = {0,0,0,0}.
  - out_last = 1 only on beta_1; exactly 4 outputs.
- REQ-037: Single-symbol block (block_start and block_end on the same transfer) in OPEN mode.
  - Required: exactly one output, {0,0,0,0}, with out_index = 1 and out_last = 1.
- REQ-038: 9 transfers with no block_end, DEPTH = 8.
  - Required: overflow = 1 after the 8th transfer and 8 outputs follow.
  - The 9th transfer is blocked because in_ready = 0.
- REQ-039: Toggle out_ready 1,0,0,1 during RUN.
  - Required: the held output is stable for 2 cycles and the sequence is unchanged against a reference model.
- REQ-040: block_start on the 3rd symbol of a FILL.
  - Required: the prior 2 symbols are discarded; outputs match a block beginning at the restart symbol.
- REQ-041: Large gammas (+30000) for 3 steps.
  - Required: saturation with no wrap, max state = 0 every step.
  - Then assert rst mid-RUN: all outputs are 0 in the same cycle, and in_ready = 1 after deassertion.
